bitstream_frame_aligner: RTL and testbench
==========================================

Name: bitstream_frame_aligner

Overview:
Controller that sequences the 2-bit/cycle live bitstream deserialization into aligned 12-bit words.
It hunts for a 12-bit sync word at any 2-bit phase, verifies it over several frames, and declares lock.
While locked, it delivers data words through a one-entry valid/ready output buffer and drops lock after repeated sync misses.
It sits between the serial front end and the word-level frame consumer.

Parameters:
SYNC_WORD    12'hB38  frame sync pattern; pairs arrive LSB-pair first (din sequence 0,2,3,0,3,2)
LOCK_CNT     3        consecutive correct sync words needed to enter LOCKED (1..15)
UNLOCK_CNT   2        consecutive missed sync words that force return to HUNT (1..15)
FRAME_WORDS  4        data words following each sync word (1..255)

Ports:
clk          in   1   clock, rising edge
rst          in   1   asynchronous active-low reset
enable       in   1   aligner run enable; low forces IDLE
din          in   2   serial bit pair
din_en       in   1   din valid this cycle
dout         out  12  aligned data word
dout_valid   out  1   dout holds an undelivered word
dout_ready   in   1   consumer accepts dout when dout_valid=1
frame_start  out  1   qualifies dout: word is first data word of its frame
locked       out  1   state==LOCKED
state        out  2   IDLE=0, HUNT=1, VERIFY=2, LOCKED=3
overflow     out  1   sticky; a data word was dropped

Behaviour:
- Reset (rst=0, async): sr=0, all counters=0, state=IDLE; dout=0, dout_valid=0, frame_start=0, locked=0, overflow=0.
- Shift: on each edge with din_en=1, sr_next={din, sr[11:2]}. All comparisons use sr_next.
- Without din_en, sr, phase and word counters hold.
- phase: 0..5 counter of pairs. A word completes on the din_en edge where phase==5; phase then wraps to 0.
- IDLE: enable=1 -> HUNT on the next edge; sr, phase and counters are cleared.
- HUNT: on every din_en edge, if sr_next==SYNC_WORD then phase:=0, good_cnt:=1, and the next state is VERIFY if LOCK_CNT>1, else LOCKED.
- Frame position: word_idx runs 0..FRAME_WORDS. Index 0 is the sync slot; after FRAME_WORDS the index wraps to 0.
- VERIFY: at each word completion in the sync slot:
  - match: good_cnt++; reaching LOCK_CNT -> LOCKED.
  - mismatch: -> HUNT, good_cnt:=0.
  - Data words in VERIFY are discarded; dout_valid is not raised.
- LOCKED, sync slot: a match sets miss_cnt:=0. A mismatch increments miss_cnt; reaching UNLOCK_CNT -> HUNT with dout_valid cleared. Alignment is kept while miss_cnt<UNLOCK_CNT.
- LOCKED, data slot: the word is offered to the output buffer at the completion edge.
  - Buffer free, or dout_ready=1 this cycle: dout:=word, dout_valid:=1, frame_start:=(word_idx==1).
  - Otherwise the word is dropped, overflow:=1 (sticky until reset), and the held word is kept.
- Output handshake:
  - Transfer when dout_valid&&dout_ready. dout_valid then clears unless a new word loads on the same edge (back-to-back throughput).
  - dout is stable while dout_valid=1 and dout_ready=0.
  - Latency: dout_valid rises on the same edge that samples the 6th pair of the word.
- enable=0 in any state: -> IDLE on the next edge; dout_valid, locked and counters are cleared; overflow is kept.
- A sync-word match on the last pair seen in HUNT is legal even when it straddles an earlier false alignment.
- Simultaneous events: a lock loss and a data-word load cannot coincide (the sync slot carries no data). enable=0 has priority over everything except rst.

Decomposition:
- Shared package aligner_pkg:
  - state encodings IDLE/HUNT/VERIFY/LOCKED
  - default SYNC_WORD
  - counter widths: phase 3 bits, good_cnt/miss_cnt 4 bits, word_idx 8 bits
- One sub-module, aligner_out_buf: the one-entry valid/ready holding register with overflow detection.
- The FSM, sr and counters stay in the top module.

Test Plan:
- Reset and idle: rst low mid-stream with dout_valid=1 -> all outputs 0 immediately; state=IDLE, overflow=0.
- Acquisition: enable=1, send 1 junk pair (din=1) then 3 frames of [0,2,3,0,3,2 + 4 data words 12'h001..12'h004].
  - state goes HUNT -> VERIFY -> LOCKED at the completion of the 3rd sync word; no dout_valid before that.
- Locked data: 2 further frames with data 12'h123,12'h456,12'h789,12'hABC; dout_ready=1.
  - Exactly 8 transfers in order; frame_start=1 only on 12'h123 words; overflow=0.
- Backpressure: dout_ready=0 for a full frame.
  - First data word is held stable; remaining 3 are dropped; overflow=1.
  - Release dout_ready -> one transfer of the held word.
- Lock loss: corrupt 2 consecutive sync words (send 12'h000) -> state=HUNT at the 2nd miss and locked=0.
  - A single corrupted sync word followed by a good one stays LOCKED.
- Gaps and disable: insert random din_en=0 cycles during locked operation -> identical word stream.
  - enable=0 for 1 cycle -> IDLE, then reacquisition requires 3 syncs.

Source files
------------

// File: rtl/aligner_pkg.sv
// Shared definitions for the bitstream frame aligner.
// Contents: FSM state encoding, default sync pattern, counter widths,
// and a helper that shifts one bit pair into the word register.
package aligner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [11:0] SYNC_WORD_DEF = 12'hB38;

    localparam int PHASE_W = 3;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 8;

    // Pair index of the sixth (last) pair of a 12-bit word
    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd5;

    // New pairs enter at the top, so after six pairs the first one sits in bits [1:0]
    function automatic logic [11:0] shift_pair(input logic [11:0] sr, input logic [1:0] pair);
        return {pair, sr[11:2]};
    endfunction

endpackage

// File: rtl/aligner_out_buf.sv
// One-entry valid/ready holding register for aligned data words.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           clears the pending word (disable or lock loss)
//   load            a data word is offered this cycle
//   word, first     offered word and its first-of-frame flag
//   dout_ready      consumer accepts the held word
//   dout, dout_valid, frame_start   held word, its valid flag and qualifier
//   overflow        sticky: an offered word found the buffer occupied
module aligner_out_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [11:0] word,
    input  logic        first,
    input  logic        dout_ready,
    output logic [11:0] dout,
    output logic        dout_valid,
    output logic        frame_start,
    output logic        overflow
);

    logic [11:0] dout_r;
    logic        valid_r;
    logic        first_r;
    logic        ovf_r;

    // Holding register: a word loads when the slot is free or drains on this same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r  <= 12'd0;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            first_r <= 1'b0;
        end else if (load) begin
            if (!valid_r || dout_ready) begin
                dout_r  <= word;
                valid_r <= 1'b1;
                first_r <= first;
            end else begin
                ovf_r   <= 1'b1;
            end
        end else if (valid_r && dout_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign dout        = dout_r;
    assign dout_valid  = valid_r;
    assign frame_start = first_r;
    assign overflow    = ovf_r;

endmodule

// File: rtl/bitstream_frame_aligner.sv
// Aligns a 2-bit/cycle bitstream into 12-bit words framed by a sync word.
// Hunts for the sync word at any pair phase, verifies it over LOCK_CNT
// frames, then delivers FRAME_WORDS data words per frame through a
// one-entry output buffer; UNLOCK_CNT consecutive sync misses drop lock.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   enable              run enable; low returns to IDLE
//   din, din_en         serial bit pair and its valid
//   dout, dout_valid, dout_ready, frame_start   word output handshake
//   locked, state       lock indication and FSM state
//   overflow            sticky word-drop flag
module bitstream_frame_aligner
    import aligner_pkg::*;
#(
    parameter logic [11:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int          LOCK_CNT    = 3,
    parameter int          UNLOCK_CNT  = 2,
    parameter int          FRAME_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  din,
    input  logic        din_en,
    output logic [11:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        frame_start,
    output logic        locked,
    output logic [1:0]  state,
    output logic        overflow
);

    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS);

    state_t             state_r, state_n_s;
    logic [11:0]        sr_r, sr_n_s, shifted_s;
    logic [PHASE_W-1:0] phase_r, phase_n_s, phase_wrap_s;
    logic [CNT_W-1:0]   good_r, good_n_s, good_inc_s;
    logic [CNT_W-1:0]   miss_r, miss_n_s, miss_inc_s;
    logic [IDX_W-1:0]   idx_r, idx_n_s;
    logic               sync_hit_s;
    logic               load_s;
    logic               first_s;
    logic               flush_s;

    assign shifted_s    = shift_pair(sr_r, din);
    assign sync_hit_s   = (shifted_s == SYNC_WORD);
    assign phase_wrap_s = (phase_r == PHASE_LAST) ? 3'd0 : phase_r + 3'd1;
    assign good_inc_s   = good_r + 4'd1;
    assign miss_inc_s   = miss_r + 4'd1;

    // Next-state, shift register, counters and output-buffer requests
    always_comb begin
        state_n_s = state_r;
        sr_n_s    = sr_r;
        phase_n_s = phase_r;
        good_n_s  = good_r;
        miss_n_s  = miss_r;
        idx_n_s   = idx_r;
        load_s    = 1'b0;
        first_s   = 1'b0;
        flush_s   = 1'b0;
        if (!enable) begin
            state_n_s = ST_IDLE;
            sr_n_s    = 12'd0;
            phase_n_s = 3'd0;
            good_n_s  = 4'd0;
            miss_n_s  = 4'd0;
            idx_n_s   = 8'd0;
            flush_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n_s = ST_HUNT;
                    sr_n_s    = 12'd0;
                    phase_n_s = 3'd0;
                    good_n_s  = 4'd0;
                    miss_n_s  = 4'd0;
                    idx_n_s   = 8'd0;
                end
                ST_HUNT: begin
                    if (din_en) begin
                        sr_n_s = shifted_s;
                        // Every pair is a candidate alignment; the sync just seen is slot 0
                        if (sync_hit_s) begin
                            state_n_s = (LOCK_CNT > 1) ? ST_VERIFY : ST_LOCKED;
                            phase_n_s = 3'd0;
                            good_n_s  = 4'd1;
                            miss_n_s  = 4'd0;
                            idx_n_s   = 8'd1;
                        end else begin
                            phase_n_s = phase_wrap_s;
                        end
                    end else begin
                        sr_n_s = sr_r;
                    end
                end
                ST_VERIFY, ST_LOCKED: begin
                    if (din_en) begin
                        sr_n_s    = shifted_s;
                        phase_n_s = phase_wrap_s;
                        if (phase_r == PHASE_LAST) begin
                            idx_n_s = (idx_r == IDX_LAST) ? 8'd0 : idx_r + 8'd1;
                            if (idx_r != 8'd0) begin
                                // Data slot: only delivered once locked
                                load_s  = (state_r == ST_LOCKED);
                                first_s = (idx_r == 8'd1);
                            end else if (state_r == ST_VERIFY) begin
                                if (sync_hit_s) begin
                                    good_n_s = good_inc_s;
                                    if (good_inc_s == LOCK_C) begin
                                        state_n_s = ST_LOCKED;
                                        miss_n_s  = 4'd0;
                                    end else begin
                                        state_n_s = ST_VERIFY;
                                    end
                                end else begin
                                    state_n_s = ST_HUNT;
                                    good_n_s  = 4'd0;
                                end
                            end else begin
                                if (sync_hit_s) begin
                                    miss_n_s = 4'd0;
                                end else begin
                                    miss_n_s = miss_inc_s;
                                    // Alignment is kept until the miss budget is exhausted
                                    if (miss_inc_s == UNLOCK_C) begin
                                        state_n_s = ST_HUNT;
                                        miss_n_s  = 4'd0;
                                        good_n_s  = 4'd0;
                                        flush_s   = 1'b1;
                                    end else begin
                                        state_n_s = ST_LOCKED;
                                    end
                                end
                            end
                        end else begin
                            idx_n_s = idx_r;
                        end
                    end else begin
                        sr_n_s = sr_r;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, shift register and frame counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            sr_r    <= 12'd0;
            phase_r <= 3'd0;
            good_r  <= 4'd0;
            miss_r  <= 4'd0;
            idx_r   <= 8'd0;
        end else begin
            state_r <= state_n_s;
            sr_r    <= sr_n_s;
            phase_r <= phase_n_s;
            good_r  <= good_n_s;
            miss_r  <= miss_n_s;
            idx_r   <= idx_n_s;
        end
    end

    aligner_out_buf u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush_s),
        .load        (load_s),
        .word        (shifted_s),
        .first       (first_s),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    assign state  = state_r;
    assign locked = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_bitstream_frame_aligner.sv
// Self-checking bench for bitstream_frame_aligner: randomized frames
// compared every cycle against a frame-position model, plus directed
// literal checks for acquisition, delivery, backpressure, lock loss,
// gaps, disable and asynchronous reset.
module tb_bitstream_frame_aligner;

    localparam logic [11:0] SYNC = 12'hB38;
    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 2;
    localparam int FW       = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  din = 2'd0;
    logic        din_en = 1'b0;
    logic        dout_ready = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic        frame_start;
    logic        locked;
    logic [1:0]  state;
    logic        overflow;

    bitstream_frame_aligner #(
        .SYNC_WORD   (SYNC),
        .LOCK_CNT    (LOCK_N),
        .UNLOCK_CNT  (UNLOCK_N),
        .FRAME_WORDS (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .din         (din),
        .din_en      (din_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .frame_start (frame_start),
        .locked      (locked),
        .state       (state),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cycles = 0;
    bit rnd_ready = 1'b0;
    logic [12:0] xq[$];
    logic [11:0] sq[$];
    logic [11:0] pat[4] = '{12'h123, 12'h456, 12'h789, 12'hABC};

    // Model: frame position kept as pairs counted since the last sync word
    int m_state, m_sr, m_pos, m_good, m_miss, m_dout, m_valid, m_fs, m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_sr = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_dout = 0; m_valid = 0; m_fs = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        int w;
        int slot;
        bit v0;
        if (!rst) begin
            model_reset();
            return;
        end
        v0 = m_valid[0];
        if (!enable) begin
            m_state = 0; m_valid = 0; m_sr = 0; m_pos = 0; m_good = 0; m_miss = 0;
            return;
        end
        if (m_state == 0) begin
            m_state = 1; m_sr = 0; m_pos = 0; m_good = 0; m_miss = 0;
            return;
        end
        if (v0 && dout_ready) m_valid = 0;
        if (!din_en) return;
        w = ((m_sr >> 2) | (int'(din) << 10)) & 32'hFFF;
        m_sr = w;
        if (m_state == 1) begin
            if (w == int'(SYNC)) begin
                m_pos = 0; m_good = 1; m_miss = 0;
                m_state = (LOCK_N > 1) ? 2 : 3;
            end
            return;
        end
        m_pos++;
        if (m_pos % 6 != 0) return;
        slot = (m_pos / 6) % (FW + 1);
        if (m_pos == 6 * (FW + 1)) m_pos = 0;
        if (slot == 0) begin
            if (m_state == 2) begin
                if (w == int'(SYNC)) begin
                    m_good++;
                    if (m_good == LOCK_N) begin m_state = 3; m_miss = 0; end
                end else begin
                    m_state = 1; m_good = 0;
                end
            end else begin
                if (w == int'(SYNC)) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin m_state = 1; m_valid = 0; m_miss = 0; end
                end
            end
        end else if (m_state == 3) begin
            if (!v0 || dout_ready) begin
                m_valid = 1; m_dout = w; m_fs = (slot == 1) ? 1 : 0;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // Per-cycle comparison against the model and transfer capture
    always @(negedge clk) begin
        check("state", int'(state), m_state);
        check("locked", int'(locked), (m_state == 3) ? 1 : 0);
        check("dout_valid", int'(dout_valid), m_valid);
        check("overflow", int'(overflow), m_ovf);
        if (m_valid != 0) begin
            check("dout", int'(dout), m_dout);
            check("frame_start", int'(frame_start), m_fs);
        end
        if (dout_valid) valid_cycles++;
        if (dout_valid && dout_ready) xq.push_back({frame_start, dout});
    end

    task automatic step(input logic [1:0] d, input logic de);
        din = d;
        din_en = de;
        if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_word(input logic [11:0] w, input bit gaps);
        for (int k = 0; k < 6; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step(2'($urandom), 1'b0);
            end
            step(w[2*k +: 2], 1'b1);
        end
    endtask

    task automatic send_frame(input logic [11:0] s, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d, input bit gaps);
        send_word(s, gaps);
        send_word(a, gaps);
        send_word(b, gaps);
        send_word(c, gaps);
        send_word(d, gaps);
    endtask

    task automatic acquire(input bit gaps);
        valid_cycles = 0;
        for (int f = 0; f < 3; f++) begin
            send_word(SYNC, gaps);
            check("acq_state", int'(state), (f < 2) ? 2 : 3);
            check("acq_model", m_state, (f < 2) ? 2 : 3);
            if (f == 2) check("acq_no_early_valid", valid_cycles, 0);
            for (int i = 1; i <= 4; i++) send_word(12'(i), gaps);
        end
    endtask

    initial begin
        logic [11:0] a1;
        logic [11:0] w;
        model_reset();
        repeat (2) step(2'd0, 1'b0);
        check("rst_state", int'(state), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b1;
        step(2'd0, 1'b0);
        enable = 1'b1;
        dout_ready = 1'b1;
        step(2'd0, 1'b0);
        check("to_hunt", int'(state), 1);

        // Acquisition after one junk pair
        step(2'd1, 1'b1);
        acquire(1'b0);
        step(2'd0, 1'b0);
        xq.delete();

        // Locked delivery, two frames
        repeat (2) send_frame(SYNC, pat[0], pat[1], pat[2], pat[3], 1'b0);
        step(2'd0, 1'b0);
        check("n_xfer", xq.size(), 8);
        foreach (xq[i]) begin
            check("xfer_word", int'(xq[i][11:0]), int'(pat[i % 4]));
            check("xfer_fs", int'(xq[i][12]), (i % 4 == 0) ? 1 : 0);
        end
        check("no_ovf", int'(overflow), 0);

        // Backpressure for one frame
        dout_ready = 1'b0;
        a1 = 12'($urandom);
        send_frame(SYNC, a1, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0);
        check("bp_hold", int'(dout), int'(a1));
        check("bp_valid", int'(dout_valid), 1);
        check("bp_ovf", int'(overflow), 1);
        xq.delete();
        dout_ready = 1'b1;
        step(2'd0, 1'b0);
        check("bp_release_n", xq.size(), 1);
        if (xq.size() > 0) check("bp_release_word", int'(xq[0][11:0]), int'(a1));
        step(2'd0, 1'b0);
        check("bp_drained", int'(dout_valid), 0);

        // Single miss keeps lock; two consecutive misses drop it
        send_frame(12'h000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        check("miss1_locked", int'(state), 3);
        send_frame(SYNC, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        check("recover_locked", int'(state), 3);
        send_word(12'h000, 1'b0);
        check("miss_a", int'(state), 3);
        for (int i = 0; i < 4; i++) send_word(12'h000, 1'b0);
        send_word(12'h000, 1'b0);
        check("lost_state", int'(state), 1);
        check("lost_locked", int'(locked), 0);
        for (int i = 0; i < 4; i++) send_word(12'h000, 1'b0);

        // Reacquire with gaps, then stream with gaps must be unaltered
        acquire(1'b1);
        step(2'd0, 1'b0);
        xq.delete();
        sq.delete();
        for (int f = 0; f < 2; f++) begin
            send_word(SYNC, 1'b1);
            for (int i = 0; i < 4; i++) begin
                w = 12'($urandom);
                sq.push_back(w);
                send_word(w, 1'b1);
            end
        end
        step(2'd0, 1'b0);
        check("gap_n", xq.size(), sq.size());
        foreach (sq[i]) begin
            if (i < xq.size()) check("gap_word", int'(xq[i][11:0]), int'(sq[i]));
        end

        // Random backpressure, model-checked only
        rnd_ready = 1'b1;
        repeat (3) send_frame(SYNC, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 1'b1);
        rnd_ready = 1'b0;
        dout_ready = 1'b1;
        step(2'd0, 1'b0);

        // One-cycle disable
        enable = 1'b0;
        step(2'd0, 1'b0);
        check("dis_state", int'(state), 0);
        check("dis_valid", int'(dout_valid), 0);
        check("dis_locked", int'(locked), 0);
        check("dis_ovf_kept", int'(overflow), 1);
        enable = 1'b1;
        step(2'd0, 1'b0);
        check("dis_hunt", int'(state), 1);
        acquire(1'b0);

        // Asynchronous reset while a word is held
        dout_ready = 1'b0;
        send_word(SYNC, 1'b0);
        send_word(12'h5A5, 1'b0);
        check("pre_rst_valid", int'(dout_valid), 1);
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_state", int'(state), 0);
        check("arst_valid", int'(dout_valid), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_fs", int'(frame_start), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_ovf", int'(overflow), 0);
        repeat (2) step(2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
